// File: rtl/elevator_shaft_if.sv
// Command/status bundle between an elevator controller (master) and the shaft plant model (slave).
interface elevator_shaft_if #(
  parameter int PW = 4
);
  logic          motor_up;
  logic          motor_down;
  logic          door_open;
  logic          floor_sensor;
  logic          at_floor;
  logic          door_closed;
  logic [PW-1:0] position;
  logic          fault;
  logic [1:0]    fault_code;

  modport master (
    output motor_up, motor_down, door_open,
    input  floor_sensor, at_floor, door_closed, position, fault, fault_code
  );

  modport slave (
    input  motor_up, motor_down, door_open,
    output floor_sensor, at_floor, door_closed, position, fault, fault_code
  );
endinterface

// File: rtl/elevator_shaft_model.sv
// Two-floor elevator car/hoistway plant: cycle-counted travel and door motion,
// landing sensor, and sticky detection of illegal command combinations.
module elevator_shaft_model #(
  parameter int TRAVEL_CYCLES  = 8,
  parameter int DOOR_CYCLES    = 4,
  parameter int OVERRUN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  elevator_shaft_if.slave  shaft
);
  localparam int PW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam int OW = $clog2(OVERRUN_CYCLES + 1);

  localparam logic [PW-1:0] POS_MAX  = PW'(TRAVEL_CYCLES);
  localparam logic [DW-1:0] DOOR_MAX = DW'(DOOR_CYCLES);
  localparam logic [OW-1:0] OVR_MAX  = OW'(OVERRUN_CYCLES);

  typedef enum logic [1:0] {
    FC_NONE = 2'b00,
    FC_BOTH = 2'b01,
    FC_DOOR = 2'b10,
    FC_OVR  = 2'b11
  } fault_code_e;

  logic [PW-1:0] pos_q, pos_d;
  logic [DW-1:0] door_q, door_d;
  logic [OW-1:0] ovr_q, ovr_d;
  logic          floor_q, floor_d;
  logic          fault_q, fault_d;
  fault_code_e   code_q, code_d;

  logic up, down, dopen, any_motor, at_floor, ovr_hit;

  assign up        = shaft.motor_up;
  assign down      = shaft.motor_down;
  assign dopen     = shaft.door_open;
  assign any_motor = up | down;
  assign at_floor  = (pos_q == '0) || (pos_q == POS_MAX);
  assign ovr_hit   = (up && pos_q == POS_MAX) || (down && pos_q == '0);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    pos_d   = pos_q;
    door_d  = door_q;
    ovr_d   = '0;
    floor_d = floor_q;
    fault_d = fault_q;
    code_d  = code_q;

    if (ovr_hit) ovr_d = (ovr_q == OVR_MAX) ? ovr_q : ovr_q + 1'b1;

    // Once a fault is latched the brake holds the car and door where they are.
    if (!fault_q) begin
      if (door_q == '0) begin
        if (up && !down && pos_q != POS_MAX)      pos_d = pos_q + 1'b1;
        else if (down && !up && pos_q != '0)      pos_d = pos_q - 1'b1;
      end

      if (dopen && at_floor && !any_motor) begin
        if (door_q != DOOR_MAX) door_d = door_q + 1'b1;
      end else if (!dopen) begin
        if (door_q != '0) door_d = door_q - 1'b1;
      end

      // Checked in code order so the lowest code wins a same-cycle tie.
      if (up && down) begin
        fault_d = 1'b1;
        code_d  = FC_BOTH;
      end else if ((any_motor && door_q != '0) || (dopen && !at_floor)) begin
        fault_d = 1'b1;
        code_d  = FC_DOOR;
      end else if (ovr_d == OVR_MAX && ovr_q != OVR_MAX) begin
        fault_d = 1'b1;
        code_d  = FC_OVR;
      end
    end

    if (pos_d == POS_MAX)  floor_d = 1'b1;
    else if (pos_d == '0)  floor_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      door_q  <= '0;
      ovr_q   <= '0;
      floor_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      pos_q   <= pos_d;
      door_q  <= door_d;
      ovr_q   <= ovr_d;
      floor_q <= floor_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign shaft.floor_sensor = floor_q;
  assign shaft.at_floor     = at_floor;
  assign shaft.door_closed  = (door_q == '0);
  assign shaft.position     = pos_q;
  assign shaft.fault        = fault_q;
  assign shaft.fault_code   = code_q;
endmodule

// File: tb/tb_elevator_shaft_model.sv
// Directed bench for elevator_shaft_model at default parameters: a vector table for
// normal travel/door behaviour plus hand sequences for reset and fault corner cases.
module tb_elevator_shaft_model;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  elevator_shaft_if #(.PW(PW)) shaft ();

  elevator_shaft_model #(
    .TRAVEL_CYCLES (8),
    .DOOR_CYCLES   (4),
    .OVERRUN_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .shaft(shaft)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic          up;
    logic          down;
    logic          dopen;
    logic [PW-1:0] pos;
    logic          at_floor;
    logic          closed;
    logic          fs;
    logic          fault;
    logic [1:0]    code;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic up, input logic down, input logic dopen,
                              input int pos, input logic af, input logic cl,
                              input logic fs, input logic flt, input logic [1:0] code);
    vec_t v;
    v.up = up; v.down = down; v.dopen = dopen;
    v.pos = PW'(pos); v.at_floor = af; v.closed = cl; v.fs = fs;
    v.fault = flt; v.code = code;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic up, input logic down, input logic dopen);
    shaft.motor_up   = up;
    shaft.motor_down = down;
    shaft.door_open  = dopen;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    shaft.motor_up = 1'b0; shaft.motor_down = 1'b0; shaft.door_open = 1'b0;
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".position"},     32'(shaft.position),     32'(v.pos));
    check({tag, ".at_floor"},     32'(shaft.at_floor),     32'(v.at_floor));
    check({tag, ".door_closed"},  32'(shaft.door_closed),  32'(v.closed));
    check({tag, ".floor_sensor"}, 32'(shaft.floor_sensor), 32'(v.fs));
    check({tag, ".fault"},        32'(shaft.fault),        32'(v.fault));
    check({tag, ".fault_code"},   32'(shaft.fault_code),   32'(v.code));
  endtask

  initial begin
    vec_t rv;
    shaft.motor_up = 1'b0; shaft.motor_down = 1'b0; shaft.door_open = 1'b0;

    // Vector table: full travel, single-cycle overruns, door cycling with saturation.
    for (int i = 1; i <= 8; i++) add(1, 0, 0, i, i == 8, 1, i == 8, 0, 2'b00);
    add(1, 0, 0, 8, 1, 1, 1, 0, 2'b00);  // one overrun cycle, no fault yet
    add(0, 0, 0, 8, 1, 1, 1, 0, 2'b00);  // clears overrun count
    add(1, 0, 0, 8, 1, 1, 1, 0, 2'b00);  // single overrun again, still no fault
    add(0, 0, 0, 8, 1, 1, 1, 0, 2'b00);
    for (int k = 1; k <= 8; k++) add(0, 1, 0, 8 - k, k == 8, 1, k != 8, 0, 2'b00);
    add(0, 0, 1, 0, 1, 0, 0, 0, 2'b00);
    add(0, 0, 1, 0, 1, 0, 0, 0, 2'b00);
    add(0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    add(0, 0, 0, 0, 1, 1, 0, 0, 2'b00);
    for (int k = 0; k < 5; k++) add(0, 0, 1, 0, 1, 0, 0, 0, 2'b00);  // door saturates at 4
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    add(0, 0, 0, 0, 1, 1, 0, 0, 2'b00);  // 4th close edge: fully closed

    // Reset state
    #2;
    rv.pos = '0; rv.at_floor = 1; rv.closed = 1; rv.fs = 0; rv.fault = 0; rv.code = 2'b00;
    check_all("reset", rv);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].up, vecs[i].down, vecs[i].dopen);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-travel
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    check("mid_travel.position", 32'(shaft.position), 32'd4);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst.position", 32'(shaft.position), 32'd0);
    check("async_rst.at_floor", 32'(shaft.at_floor), 32'd1);
    check("async_rst.door_closed", 32'(shaft.door_closed), 32'd1);
    check("async_rst.fault", 32'(shaft.fault), 32'd0);
    do_reset();

    // Reset with door part-open
    step(0, 0, 1);
    step(0, 0, 1);
    check("door_part.door_closed", 32'(shaft.door_closed), 32'd0);
    do_reset();
    check("door_rst.door_closed", 32'(shaft.door_closed), 32'd1);

    // Both motors at pos 3; brake holds position afterwards
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(1, 1, 0);
    check("both.fault", 32'(shaft.fault), 32'd1);
    check("both.code", 32'(shaft.fault_code), 32'd1);
    check("both.position", 32'(shaft.position), 32'd3);
    for (int i = 0; i < 10; i++) begin
      step(logic'(i % 2), logic'((i / 2) % 2), logic'(i % 3 == 0));
      check($sformatf("both_hold%0d.position", i), 32'(shaft.position), 32'd3);
      check($sformatf("both_hold%0d.code", i), 32'(shaft.fault_code), 32'd1);
    end
    do_reset();

    // Door interlock at floor 1
    step(0, 0, 1);
    step(0, 0, 1);
    check("intlk.door_closed_pre", 32'(shaft.door_closed), 32'd0);
    step(1, 0, 1);
    check("intlk.fault", 32'(shaft.fault), 32'd1);
    check("intlk.code", 32'(shaft.fault_code), 32'd2);
    check("intlk.position", 32'(shaft.position), 32'd0);
    check("intlk.door_closed", 32'(shaft.door_closed), 32'd0);
    step(1, 0, 0);
    check("intlk_frozen.position", 32'(shaft.position), 32'd0);
    check("intlk_frozen.door_closed", 32'(shaft.door_closed), 32'd0);
    check("intlk_frozen.code", 32'(shaft.fault_code), 32'd2);
    do_reset();

    // Overtravel at floor 2
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    step(1, 0, 0);
    check("ovr_up1.fault", 32'(shaft.fault), 32'd0);
    step(1, 0, 0);
    check("ovr_up2.fault", 32'(shaft.fault), 32'd1);
    check("ovr_up2.code", 32'(shaft.fault_code), 32'd3);
    check("ovr_up2.position", 32'(shaft.position), 32'd8);
    do_reset();

    // Overtravel at floor 1
    step(0, 1, 0);
    check("ovr_dn1.fault", 32'(shaft.fault), 32'd0);
    step(0, 1, 0);
    check("ovr_dn2.fault", 32'(shaft.fault), 32'd1);
    check("ovr_dn2.code", 32'(shaft.fault_code), 32'd3);
    do_reset();

    // Priority: both motors and door open mid-shaft in one cycle
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(1, 1, 1);
    check("prio.fault", 32'(shaft.fault), 32'd1);
    check("prio.code", 32'(shaft.fault_code), 32'd1);
    step(0, 0, 1);
    check("prio_later.code", 32'(shaft.fault_code), 32'd1);
    check("prio_later.position", 32'(shaft.position), 32'd4);
    do_reset();
    check("final_rst.fault", 32'(shaft.fault), 32'd0);
    check("final_rst.code", 32'(shaft.fault_code), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/elevator_shaft_model.md
# elevator_shaft_model

Synthesizable plant model of a two-floor elevator car and hoistway. It is the counterpart of the elevator controller: it consumes the controller's `motor_up`, `motor_down` and `door_open` commands and produces the `floor_sensor` input the controller samples. Car travel and door movement are modelled as cycle counters, and illegal command combinations are flagged as sticky faults. It is used in closed-loop benches and on FPGA demo boards in place of a real shaft.

## Interface

**Parameters**
- `TRAVEL_CYCLES`, default 8: clock cycles of motor drive needed to move the car floor 1 → floor 2 (and back); must be ≥ 2.
- `DOOR_CYCLES`, default 4: cycles for the door to go fully closed ↔ fully open; must be ≥ 1.
- `OVERRUN_CYCLES`, default 2: consecutive cycles of driving into an end stop that raise an overtravel fault; must be ≥ 1.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset. One clock; the reset is asynchronous and active-low.
- `motor_up`, input, 1: command from the controller to drive the car toward floor 2.
- `motor_down`, input, 1: command from the controller to drive the car toward floor 1.
- `door_open`, input, 1: command from the controller to open the door (held high = open, low = close).
- `floor_sensor`, output, 1: last floor landed at; 0 = floor 1, 1 = floor 2.
- `at_floor`, output, 1: car is exactly at a landing.
- `door_closed`, output, 1: door is fully closed.
- `position`, output, `$clog2(TRAVEL_CYCLES+1)`: car position; 0 = floor 1, `TRAVEL_CYCLES` = floor 2.
- `fault`, output, 1: sticky fault flag.
- `fault_code`, output, 2: code of the first fault; 00 none, 01 both motors, 10 door/motion interlock, 11 overtravel.

## Operation

- **State.** `pos` holds 0..`TRAVEL_CYCLES`. `door_cnt` holds 0..`DOOR_CYCLES`. `ovr_cnt` holds 0..`OVERRUN_CYCLES`. There is also a sticky `fault`/`fault_code` pair.
- **Motion.** Motion occurs only when `fault`=0 and `door_cnt`=0.
  - `motor_up` & !`motor_down` & `pos`<`TRAVEL_CYCLES` → `pos`+1.
  - `motor_down` & !`motor_up` & `pos`>0 → `pos`−1.
  - Otherwise `pos` holds.
- **Door.** The door moves only when `fault`=0.
  - `door_open` & `at_floor` & no motor command → `door_cnt`+1, saturating at `DOOR_CYCLES`.
  - !`door_open` → `door_cnt`−1, saturating at 0.
  - Otherwise `door_cnt` holds.
- **`floor_sensor`.** Set to 1 when next `pos` = `TRAVEL_CYCLES`. Cleared to 0 when next `pos` = 0. Holds its value mid-shaft.
- **Status outputs.** `at_floor` = (`pos`==0 || `pos`==`TRAVEL_CYCLES`). `door_closed` = (`door_cnt`==0). `position` = `pos`.
- **Overtravel counter.** `ovr_cnt` increments, saturating, on each cycle with (`motor_up` & `pos`==`TRAVEL_CYCLES`) or (`motor_down` & `pos`==0). Any other cycle clears it.
- **Fault detection.** Faults are evaluated every cycle while `fault`=0. If several conditions hit in the same cycle, the lowest code wins.
  - 01: `motor_up` & `motor_down`.
  - 10: (`motor_up` | `motor_down`) & `door_cnt`≠0, or `door_open` & !`at_floor`.
  - 11: `ovr_cnt` would reach `OVERRUN_CYCLES`.
- **Fault handling.** On detection, `fault`←1 and `fault_code`←code. Once set, `pos` and `door_cnt` freeze (brake applied) and `fault_code` is never overwritten. Only `rst_n` clears a fault.

## Timing

- **Reset values.** `rst_n`=0 forces, immediately and independent of `clk`: `pos`=0, `door_cnt`=0, `ovr_cnt`=0, `floor_sensor`=0, `at_floor`=1, `door_closed`=1, `position`=0, `fault`=0, `fault_code`=00.
- **Register alignment.** All outputs are registered or derived directly from registers. `floor_sensor`, `at_floor` and `door_closed` change on the same edge that updates `pos`/`door_cnt`; there is no extra pipeline stage.
- **Input sampling.** Inputs are sampled on the rising edge. A command present at edge N affects outputs just after edge N.
- **Full floor-to-floor move.** `TRAVEL_CYCLES` sampled edges of `motor_up`. With the default of 8, `floor_sensor` rises after the 8th edge and `at_floor` is 0 after edges 1..7.
- **Door.** After the first edge with `door_open` at a landing, `door_closed` falls. It rises after the `door_cnt`-th edge of `door_open`=0.
- **Fault.** `fault` asserts after the edge that samples the violating inputs.
- **Mid-operation reset.** `rst_n` asserted mid-travel or with the door part-open returns the car to floor 1, door closed, with no fault. There is no position retention.
- **Reset release.** Release of `rst_n` is synchronised by the user. The first active edge after release is a normal cycle.

## Test plan

- **Reset.** Assert `rst_n`=0 mid-cycle with `pos`=4 → outputs immediately at reset values: `position`=0, `at_floor`=1, `door_closed`=1, `fault`=0.
- **Travel up and down.** Hold `motor_up` for 8 edges (defaults) → `position` steps 1..8, `at_floor`=0 after edges 1–7, `floor_sensor`=1 after edge 8. Then hold `motor_down` for 8 edges → `floor_sensor`=0 and `position`=0 after edge 8.
- **Both motors.** Drive `motor_up`=`motor_down`=1 at `pos`=3 → `fault`=1, `fault_code`=01 after that edge. `position` stays 3 for 10 further cycles of any stimulus.
- **Door interlock.** At floor 1, set `door_open`=1 for 2 edges (`door_closed`=0), then `motor_up`=1 → `fault_code`=10, `position` stays 0, `door_closed` stays 0.
- **Overtravel.** At `pos`=8, hold `motor_up` → no fault after 1 edge; `fault`=1, `fault_code`=11 after the 2nd edge. A single-cycle overrun followed by `motor_up`=0 → no fault.
- **Fault priority.** In one cycle at `pos`=4, apply `motor_up`=`motor_down`=1 and `door_open`=1 → `fault_code`=01. A later door violation does not change `fault_code`.
